// File: rtl/rf_wport_arb_pkg.sv
// rf_wport_arb_pkg
// Shared definitions for the register-file write-port arbiter slice:
// register-file geometry, enable encodings, the buffered write entry
// layout and the write-source select encoding.
package rf_wport_arb_pkg;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegAddrBus = RegNumLog2;
  localparam int RegBus     = 32;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;

  // Reset is asynchronous and active-high in this block.
  localparam logic RstEnable = 1'b1;

  // Default number of buffered long-latency results.
  localparam int FifoDepth = 2;
  // Default consecutive full-FIFO cycles under WB before wb_hold.
  localparam int StarveLim = 8;

  // One buffered write: 5-bit address above 32-bit data (37 bits).
  typedef struct packed {
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } wr_entry_t;

  localparam int EntryW = $bits(wr_entry_t);

  // Which source drives the write port at the next edge.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_WB,
    SEL_FIFO,
    SEL_BYPASS
  } wr_sel_e;

endpackage

// File: rtl/rf_wport_arb_wb_fifo.sv
// rf_wb_fifo
// Small synchronous FIFO that buffers long-latency results while the
// writeback stage owns the register-file write port.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, din     write an entry (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   full, empty   occupancy flags
//   head          current head entry, valid while !empty
module rf_wb_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH = FifoDepth,
  parameter int WIDTH = EntryW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0] wr_ptr;
  logic [PtrW:0] rd_ptr;

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                   (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign head    = mem[rd_ptr[PtrW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrOne;
      if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PtrW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wport_arb.sv
// rf_wport_arb
// Owns the single write port of the 32x32 register file. The writeback
// stage has fixed priority; long-latency results are buffered in a FIFO
// and written when WB is idle. A pending-write scoreboard raises a decode
// stall for operands whose long-latency write has not yet reached the port.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   wb_we, wb_waddr, wb_wdata        writeback write request
//   lu_issue, lu_issue_addr          long-latency issue (marks dest pending)
//   lu_valid, lu_waddr, lu_wdata     long-latency result
//   lu_ready                         result can be accepted (FIFO not full)
//   rd_en1/rdaddr1, rd_en2/rdaddr2   decode operand reads
//   stall_req                        combinational decode stall
//   wb_hold                          registered one-cycle WB back-off request
//   wr_en, wraddr, wrdata            registered write to reg_file
//   err                              sticky protocol error
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = FifoDepth,
  parameter int STARVE_LIM = StarveLim
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [RegAddrBus-1:0] wb_waddr,
  input  logic [RegBus-1:0]     wb_wdata,
  input  logic                  lu_issue,
  input  logic [RegAddrBus-1:0] lu_issue_addr,
  input  logic                  lu_valid,
  input  logic [RegAddrBus-1:0] lu_waddr,
  input  logic [RegBus-1:0]     lu_wdata,
  output logic                  lu_ready,
  input  logic                  rd_en1,
  input  logic [RegAddrBus-1:0] rdaddr1,
  input  logic                  rd_en2,
  input  logic [RegAddrBus-1:0] rdaddr2,
  output logic                  stall_req,
  output logic                  wb_hold,
  output logic                  wr_en,
  output logic [RegAddrBus-1:0] wraddr,
  output logic [RegBus-1:0]     wrdata,
  output logic                  err
);

  localparam int CntW = $clog2(STARVE_LIM) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STARVE_LIM - 1);
  localparam logic [CntW-1:0] CntOne  = 1;

  logic              wb_active;
  logic              lu_accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EntryW-1:0] fifo_head;
  wr_entry_t         head_ent;
  wr_entry_t         lu_ent;
  logic              fifo_push;
  logic              fifo_pop;
  wr_sel_e           sel;

  logic [RegNum-1:0] pend;
  logic [RegNum-1:0] set_vec;
  logic [RegNum-1:0] clr_vec;
  logic              err_now;
  logic [CntW-1:0]   starve_cnt;
  logic              starving;

  // A write to r0 is treated as no request at all.
  assign wb_active = wb_we && (wb_waddr != '0);
  assign lu_ready  = !fifo_full;
  assign lu_accept = lu_valid && lu_ready;
  assign head_ent  = fifo_head;
  assign lu_ent    = '{addr: lu_waddr, data: lu_wdata};
  assign starving  = fifo_full && wb_active;

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (lu_ent),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Source selection. A result arriving with WB active is buffered; with
  // the FIFO non-empty it queues behind the head to keep strict ordering;
  // only when everything is idle does it bypass straight to the port.
  always_comb begin
    sel       = SEL_NONE;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (wb_active) begin
      sel       = SEL_WB;
      fifo_push = lu_accept;
    end else if (!fifo_empty) begin
      sel       = SEL_FIFO;
      fifo_pop  = 1'b1;
      fifo_push = lu_accept;
    end else if (lu_accept) begin
      sel       = SEL_BYPASS;
    end
  end

  // Pending bits clear when the long-latency write is registered to the
  // port; a same-cycle issue to that register re-sets it.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (lu_issue && (lu_issue_addr != '0)) set_vec[lu_issue_addr] = 1'b1;
    if (sel == SEL_FIFO)   clr_vec[head_ent.addr] = 1'b1;
    if (sel == SEL_BYPASS) clr_vec[lu_waddr]      = 1'b1;
  end

  // pend[0] is never set, so a result to r0 always flags an error.
  assign err_now = (lu_issue && (lu_issue_addr != '0) && pend[lu_issue_addr]) ||
                   (wb_active && pend[wb_waddr]) ||
                   (lu_accept && !pend[lu_waddr]);

  assign stall_req = ((rd_en1 == ReadEnable) && (rdaddr1 != '0) && pend[rdaddr1]) ||
                     ((rd_en2 == ReadEnable) && (rdaddr2 != '0) && pend[rdaddr2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_en  <= WriteDisable;
      wraddr <= '0;
      wrdata <= ZeroWord;
    end else begin
      case (sel)
        SEL_WB: begin
          wr_en  <= WriteEnable;
          wraddr <= wb_waddr;
          wrdata <= wb_wdata;
        end
        SEL_FIFO: begin
          wr_en  <= WriteEnable;
          wraddr <= head_ent.addr;
          wrdata <= head_ent.data;
        end
        SEL_BYPASS: begin
          wr_en  <= WriteEnable;
          wraddr <= lu_waddr;
          wrdata <= lu_wdata;
        end
        default: wr_en <= WriteDisable;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      pend <= (pend & ~clr_vec) | set_vec;
      if (err_now) err <= 1'b1;
    end
  end

  // Starvation guard: after STARVE_LIM straight cycles of WB writing while
  // the FIFO is full, ask the pipeline for one bubble so the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end else if (starving) begin
      if (starve_cnt == CntLast) begin
        starve_cnt <= '0;
        wb_hold    <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + CntOne;
        wb_hold    <= 1'b0;
      end
    end else begin
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// tb_rf_wport_arb
// Self-checking bench for rf_wport_arb: directed scenarios followed by a
// randomized legal-traffic phase, all compared against a queue-based
// reference model of the write port, scoreboard and starvation rule.
module tb_rf_wport_arb;

  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rd_en1;
  logic [4:0]  rdaddr1;
  logic        rd_en2;
  logic [4:0]  rdaddr2;
  logic        stall_req;
  logic        wb_hold;
  logic        wr_en;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  bit          pend_m[32];
  logic        m_wr_en;
  logic [4:0]  m_wraddr;
  logic [31:0] m_wrdata;
  logic        m_hold;
  logic        m_err;
  int          run_len;

  rf_wport_arb #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .lu_issue      (lu_issue),
    .lu_issue_addr (lu_issue_addr),
    .lu_valid      (lu_valid),
    .lu_waddr      (lu_waddr),
    .lu_wdata      (lu_wdata),
    .lu_ready      (lu_ready),
    .rd_en1        (rd_en1),
    .rdaddr1       (rdaddr1),
    .rd_en2        (rd_en2),
    .rdaddr2       (rdaddr2),
    .stall_req     (stall_req),
    .wb_hold       (wb_hold),
    .wr_en         (wr_en),
    .wraddr        (wraddr),
    .wrdata        (wrdata),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    lu_issue = 0; lu_issue_addr = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    rd_en1 = 0; rdaddr1 = 0; rd_en2 = 0; rdaddr2 = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (pend_m[i]) pend_m[i] = 0;
    m_wr_en = 0; m_wraddr = 0; m_wrdata = 0;
    m_hold = 0; m_err = 0; run_len = 0;
  endtask

  // One clock cycle with the inputs currently driven: check combinational
  // outputs, advance the model, then check registered outputs after the edge.
  task automatic cycle();
    bit   wb_act, ready, acc, stall, full_before;
    int   clr;
    ent_t e;
    #1;
    wb_act      = wb_we && (wb_waddr != 0);
    ready       = mq.size() < FIFO_DEPTH;
    full_before = !ready;
    acc         = lu_valid && ready;
    stall       = (rd_en1 && rdaddr1 != 0 && pend_m[rdaddr1]) ||
                  (rd_en2 && rdaddr2 != 0 && pend_m[rdaddr2]);
    chk("lu_ready", lu_ready, ready);
    chk("stall_req", stall_req, stall);

    if (lu_issue && lu_issue_addr != 0 && pend_m[lu_issue_addr]) m_err = 1;
    if (wb_act && pend_m[wb_waddr]) m_err = 1;
    if (acc && !pend_m[lu_waddr]) m_err = 1;

    clr = -1;
    if (wb_act) begin
      m_wr_en = 1; m_wraddr = wb_waddr; m_wrdata = wb_wdata;
      if (acc) mq.push_back('{a: lu_waddr, d: lu_wdata});
    end else if (mq.size() != 0) begin
      e = mq.pop_front();
      m_wr_en = 1; m_wraddr = e.a; m_wrdata = e.d;
      clr = int'(e.a);
      if (acc) mq.push_back('{a: lu_waddr, d: lu_wdata});
    end else if (acc) begin
      m_wr_en = 1; m_wraddr = lu_waddr; m_wrdata = lu_wdata;
      clr = int'(lu_waddr);
    end else begin
      m_wr_en = 0;
    end

    if (clr >= 0) pend_m[clr] = 0;
    if (lu_issue && lu_issue_addr != 0) pend_m[lu_issue_addr] = 1;

    if (full_before && wb_act) begin
      run_len++;
      if (run_len == STARVE_LIM) begin
        m_hold = 1; run_len = 0;
      end else begin
        m_hold = 0;
      end
    end else begin
      run_len = 0; m_hold = 0;
    end

    @(posedge clk);
    #1;
    chk("wr_en", wr_en, m_wr_en);
    chk("wraddr", wraddr, m_wraddr);
    chk("wrdata", wrdata, m_wrdata);
    chk("wb_hold", wb_hold, m_hold);
    chk("err", err, m_err);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    rd_en1 = 1; rdaddr1 = 5'd5;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_wb_hold", wb_hold, 0);
    chk("rst_err", err, 0);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_stall", stall_req, 0);
    idle();
  endtask

  initial begin
    int          n;
    int          idx;
    bit          have_res;
    bit          acc_pre;
    bit          issued;
    logic [4:0]  res_a;
    logic [31:0] res_d;
    logic [4:0]  ia;
    logic [4:0]  outst[$];

    idle();
    rst = 1;
    #2;
    do_reset();

    // Bypass path
    lu_issue = 1; lu_issue_addr = 5'd5;
    cycle();
    idle(); rd_en1 = 1; rdaddr1 = 5'd5;
    #1 chk("bypass_stall_before", stall_req, 1);
    cycle();
    lu_valid = 1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
    cycle();
    chk("bypass_wr_en", wr_en, 1);
    chk("bypass_wraddr", wraddr, 5);
    chk("bypass_wrdata", wrdata, 32'hDEADBEEF);
    idle(); rd_en1 = 1; rdaddr1 = 5'd5;
    #1 chk("bypass_stall_after", stall_req, 0);

    // Priority and buffering
    idle(); lu_issue = 1; lu_issue_addr = 5'd7;
    cycle();
    idle(); wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h11;
    lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'h22;
    cycle();
    chk("prio_wb_addr", wraddr, 3);
    chk("prio_wb_data", wrdata, 32'h11);
    idle();
    cycle();
    chk("prio_lu_addr", wraddr, 7);
    chk("prio_lu_data", wrdata, 32'h22);

    idle(); lu_issue = 1; lu_issue_addr = 5'd8;
    cycle();
    lu_issue_addr = 5'd10;
    cycle();
    idle(); wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h33;
    lu_valid = 1; lu_waddr = 5'd8; lu_wdata = 32'h88;
    cycle();
    wb_wdata = 32'h34; lu_waddr = 5'd10; lu_wdata = 32'hAA;
    cycle();
    idle(); wb_we = 1; wb_waddr = 5'd4;
    #1 chk("buf_lu_ready_full", lu_ready, 0);

    // Starvation: WB every cycle with a full FIFO
    n = 0;
    for (int i = 0; i < 20; i++) begin
      idle(); wb_we = 1; wb_waddr = 5'd4; wb_wdata = 32'h100 + i;
      cycle();
      n++;
      if (m_hold) break;
    end
    chk("starve_cycles", n, STARVE_LIM);
    chk("starve_hold", wb_hold, 1);
    idle();
    cycle();
    chk("starve_pop_wr_en", wr_en, 1);
    chk("starve_pop_addr", wraddr, 8);
    chk("starve_pop_data", wrdata, 32'h88);
    chk("starve_hold_off", wb_hold, 0);
    #1 chk("starve_lu_ready", lu_ready, 1);
    cycle();
    chk("starve_drain_addr", wraddr, 10);

    // r0 handling
    idle(); lu_issue = 1; lu_issue_addr = 5'd11;
    cycle();
    idle(); wb_we = 1; wb_waddr = 5'd2; wb_wdata = 32'h55;
    lu_valid = 1; lu_waddr = 5'd11; lu_wdata = 32'hBB;
    cycle();
    idle(); wb_we = 1; wb_waddr = 5'd0; wb_wdata = 32'h66;
    rd_en1 = 1; rdaddr1 = 5'd0;
    #1 chk("r0_no_stall", stall_req, 0);
    cycle();
    chk("r0_drain_addr", wraddr, 11);
    chk("r0_drain_data", wrdata, 32'hBB);
    cycle();
    chk("r0_no_write", wr_en, 0);
    chk("r0_addr_held", wraddr, 11);

    // Randomized legal traffic
    have_res = 0; res_a = 0; res_d = 0;
    for (int c = 0; c < 400; c++) begin
      idle();
      if (!m_hold && ($urandom % 2) == 1) begin
        wb_waddr = 5'($urandom);
        wb_wdata = $urandom;
        wb_we = !pend_m[wb_waddr];
      end
      ia = 5'($urandom_range(31, 1));
      issued = (($urandom % 3) == 0) && !pend_m[ia];
      lu_issue = issued; lu_issue_addr = ia;
      if (!have_res && outst.size() > 0 && ($urandom % 2) == 1) begin
        idx = $urandom_range(outst.size() - 1, 0);
        res_a = outst[idx];
        outst.delete(idx);
        res_d = $urandom;
        have_res = 1;
      end
      lu_valid = have_res; lu_waddr = res_a; lu_wdata = res_d;
      rd_en1 = 1'($urandom); rdaddr1 = 5'($urandom);
      rd_en2 = 1'($urandom); rdaddr2 = 5'($urandom);
      acc_pre = have_res && (mq.size() < FIFO_DEPTH);
      cycle();
      if (acc_pre) have_res = 0;
      if (issued) outst.push_back(ia);
    end
    chk("random_no_err", err, 0);

    // Errors
    do_reset();
    lu_issue = 1; lu_issue_addr = 5'd9;
    cycle();
    cycle();
    chk("err_double_issue", err, 1);
    idle();
    repeat (3) cycle();
    chk("err_sticky", err, 1);
    do_reset();
    lu_valid = 1; lu_waddr = 5'd12; lu_wdata = 32'h12;
    cycle();
    chk("err_nonpending_result", err, 1);

    // Asynchronous reset mid-operation
    do_reset();
    lu_issue = 1; lu_issue_addr = 5'd4;
    cycle();
    lu_issue_addr = 5'd13;
    cycle();
    lu_issue_addr = 5'd14;
    cycle();
    idle(); wb_we = 1; wb_waddr = 5'd2; wb_wdata = 32'h77;
    lu_valid = 1; lu_waddr = 5'd13; lu_wdata = 32'hD13;
    cycle();
    lu_waddr = 5'd14; lu_wdata = 32'hD14;
    lu_issue = 1; lu_issue_addr = 5'd4;
    cycle();
    chk("ar_pre_err", err, 1);
    idle(); rd_en1 = 1; rdaddr1 = 5'd4;
    #2;
    rst = 1;
    #1;
    chk("ar_wr_en", wr_en, 0);
    chk("ar_lu_ready", lu_ready, 1);
    chk("ar_stall", stall_req, 0);
    chk("ar_err", err, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    idle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("ar_no_write", wr_en, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wport_arb.md
Name: rf_wport_arb

Overview:
- Owns the single write port of the 32x32 general register file.
- Arbitrates between two write sources:
  - the pipeline writeback stage, which has fixed priority and cannot be back-pressured;
  - the long-latency unit (divider / load return), whose results are buffered in a small FIFO.
- Keeps a pending-write scoreboard for long-latency destinations and raises a decode stall when an operand read hits a pending register.
- Sits between the WB stage / long-latency unit and reg_file, and feeds the ID-stage stall logic.

Parameters:
- FIFO_DEPTH, 2, number of buffered long-latency results (power of two, >=2).
- STARVE_LIM, 8, consecutive cycles with a full FIFO before the block asserts wb_hold.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_we  in  1  writeback write request.
- wb_waddr  in  5  writeback destination register.
- wb_wdata  in  32  writeback data.
- lu_issue  in  1  long-latency op issued this cycle; marks its destination pending.
- lu_issue_addr  in  5  destination register of the issued op.
- lu_valid  in  1  long-latency result valid.
- lu_waddr  in  5  result destination.
- lu_wdata  in  32  result data.
- lu_ready  out  1  FIFO can accept a result (!full).
- rd_en1  in  1  decode operand-1 read enable.
- rdaddr1  in  5  decode operand-1 address.
- rd_en2  in  1  decode operand-2 read enable.
- rdaddr2  in  5  decode operand-2 address.
- stall_req  out  1  decode must stall (combinational).
- wb_hold  out  1  registered; pipeline must present wb_we=0 in the next cycle.
- wr_en  out  1  registered write enable to reg_file.
- wraddr  out  5  registered write address to reg_file.
- wrdata  out  32  registered write data to reg_file.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - wr_en=0, wraddr=0, wrdata=0, wb_hold=0, err=0.
  - FIFO empty, so lu_ready=1.
  - All pending bits clear, so stall_req=0.
  - Starve counter=0.
- WB active means wb_we=1 and wb_waddr!=0. A write to r0 counts as idle and is never forwarded.
- Result acceptance: a result is accepted on a cycle with lu_valid && lu_ready. lu_valid while !lu_ready is held by the source and has no effect.
- Write selection each cycle, by priority. The choice is registered to wr_en/wraddr/wrdata at the next edge, so there is 1-cycle latency to reg_file.
  1. WB active: forward the WB write.
  2. Else FIFO not empty: pop the head and forward it.
  3. Else a result is accepted this cycle: bypass it straight to the output, with no push.
  4. Else: wr_en=0. wraddr and wrdata hold their previous values.
- When WB is active, an accepted result is pushed. The FIFO cannot be full in that case, because lu_ready=!full.
- The FIFO never pushes and pops in the same cycle from the same entry; ordering is strict FIFO.
- Scoreboard:
  - lu_issue with a nonzero address sets pend[lu_issue_addr] at the edge.
  - A pending bit clears at the edge where that register's long-latency write is registered to the output. reg_file's same-cycle bypass covers the following read.
  - If set and clear hit the same register in the same cycle, set wins.
- stall_req = (rd_en1 && rdaddr1!=0 && pend[rdaddr1]) || (rd_en2 && rdaddr2!=0 && pend[rdaddr2]).
- err sets and stays set until rst on any of:
  - lu_issue to an already-pending register;
  - WB active to a pending register;
  - an accepted result whose address is not pending.
- Starvation:
  - The counter increments each cycle that the FIFO is full and WB is active, and resets otherwise.
  - On reaching STARVE_LIM-1, wb_hold is asserted for exactly one cycle and the counter clears.
  - The following cycle drains one FIFO entry.
- Reset mid-operation: the FIFO, pending bits and outputs clear immediately, without waiting for a clock edge. Results in flight are discarded.

Decomposition:
- Shared package/defines:
  - RegAddrBus, RegBus, RegNum, RegNumLog2, ZeroWord;
  - WriteEnable/ReadEnable;
  - RstEnable, redefined active-high for async use.
- Add a new define for FIFO_DEPTH.
- One sub-module: rf_wb_fifo, a synchronous FIFO with push/pop/full/empty/head outputs, width 37 (5-bit address + 32-bit data).

Test Plan:
- Bypass path: WB idle, lu_issue r5, then lu_valid r5 / 0xDEADBEEF. Required:
  - stall_req=1 for rdaddr1=5 before the result;
  - next cycle wr_en=1, wraddr=5, wrdata=0xDEADBEEF;
  - pend[5] clear, stall_req=0.
- Priority and buffering:
  - WB writes r3=0x11 while lu_valid r7=0x22. Required: output r3 first, then r7 the next idle cycle.
  - Two further results during continuous WB. Required: lu_ready=0 after 2 pushes.
- Starvation: WB active every cycle with the FIFO full for 8 cycles. Required:
  - wb_hold pulses 1 cycle;
  - next cycle pops the FIFO head;
  - lu_ready returns to 1.
- r0 handling:
  - wb_we=1 with waddr=0. Required: no write output, FIFO allowed to drain.
  - rdaddr1=0 with rd_en1=1. Required: never stalls.
- Errors:
  - Double lu_issue to r9. Required: err=1 and it stays set.
  - Result to non-pending r12. Required: err=1.
- Async reset: assert rst between clock edges with 2 entries buffered and pend[4] set. Required, immediately:
  - wr_en=0, lu_ready=1, stall_req=0, err=0;
  - no writes after release.
